matrix_fifo_sync: RTL

//   Parametrised single-clock FIFO for the matrix/feature-map datapath. Successor to the vendor async FIFO buffer.

---
 rtl/matrix_fifo_pkg.sv | 18 +
 rtl/matrix_fifo_ram.sv | 28 ++
 rtl/matrix_fifo_sync.sv | 136 +++++++++++++
 3 files changed

// File: rtl/matrix_fifo_pkg.sv
// Shared mode constants and parameter helpers for the matrix datapath FIFO.
`define MATRIX_FIFO_THR_OK(dw, af, ae) (((af) <= (1 << (dw))) && ((ae) < (1 << (dw))))

package matrix_fifo_pkg;

    localparam int FIFO_STD  = 0;
    localparam int FIFO_FWFT = 1;

    // One extra wrap bit above the address bits.
    function automatic int ptr_width(input int depth_width);
        return depth_width + 1;
    endfunction

    function automatic bit thresholds_ok(input int depth_width, input int af, input int ae);
        return `MATRIX_FIFO_THR_OK(depth_width, af, ae);
    endfunction

endpackage

// File: rtl/matrix_fifo_ram.sv
// Simple dual-port storage: one write port, one registered read port.
module matrix_fifo_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [0:(1 << ADDR_WIDTH)-1];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Only the read register is reset so the output starts at zero; the array is not cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/matrix_fifo_sync.sv
// Single-clock FIFO with standard or first-word-fall-through reads, optional
// output register, registered water level and almost thresholds.
module matrix_fifo_sync
    import matrix_fifo_pkg::*;
#(
    parameter int DATA_WIDTH       = 8,
    parameter int DEPTH_WIDTH      = 10,
    parameter int FWFT             = 0,
    parameter int OUTPUT_REG       = 0,
    parameter int ALMOST_FULL_NUM  = 1020,
    parameter int ALMOST_EMPTY_NUM = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_full,
    output logic                  almost_full,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  rd_empty,
    output logic                  almost_empty,
    output logic [DEPTH_WIDTH:0]  water_level,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int            PW      = ptr_width(DEPTH_WIDTH);
    localparam logic [PW-1:0] DEPTH_L = PW'(1 << DEPTH_WIDTH);
    localparam logic [PW-1:0] AF_L    = PW'(ALMOST_FULL_NUM);
    localparam logic [PW-1:0] AE_L    = PW'(ALMOST_EMPTY_NUM);

    if (!thresholds_ok(DEPTH_WIDTH, ALMOST_FULL_NUM, ALMOST_EMPTY_NUM)) begin : g_bad_thresholds
        $error("matrix_fifo_sync: almost thresholds out of range for this depth");
    end

    logic [PW-1:0]         wr_ptr, rd_ptr, wr_ptr_next, rd_ptr_next, level_next;
    logic                  wr_acc, rd_acc, fetch, out_valid, out_valid_next;
    logic [DATA_WIDTH-1:0] ram_q;

    // Handshake: a write is taken when wr_en && !wr_full, a read when rd_en && !rd_empty,
    // using the flags registered before the edge; flush masks both for that cycle.
    always_comb begin
        wr_acc         = wr_en && !wr_full && !flush;
        rd_acc         = rd_en && !rd_empty && !flush;
        fetch          = rd_acc;
        out_valid_next = 1'b0;
        if (FWFT == FIFO_FWFT) begin
            // Refill the output stage whenever it is empty or being popped.
            fetch          = !flush && (wr_ptr != rd_ptr) && (!out_valid || rd_acc);
            out_valid_next = !flush && (fetch || (out_valid && !rd_acc));
        end
        wr_ptr_next = flush ? '0 : wr_ptr + PW'(wr_acc);
        rd_ptr_next = flush ? '0 : rd_ptr + PW'(fetch);
        // The prefetched word has left the RAM but still counts as stored.
        level_next  = wr_ptr_next - rd_ptr_next + PW'(out_valid_next);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            out_valid    <= 1'b0;
            water_level  <= '0;
            wr_full      <= 1'b0;
            almost_full  <= 1'b0;
            rd_empty     <= 1'b1;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            wr_ptr       <= wr_ptr_next;
            rd_ptr       <= rd_ptr_next;
            out_valid    <= out_valid_next;
            water_level  <= level_next;
            wr_full      <= (level_next == DEPTH_L);
            almost_full  <= (level_next >= AF_L);
            almost_empty <= (level_next <= AE_L);
            rd_empty     <= (FWFT == FIFO_FWFT) ? !out_valid_next : (level_next == '0);
            overflow     <= wr_en && wr_full && !flush;
            underflow    <= rd_en && rd_empty && !flush;
        end
    end

    matrix_fifo_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(DEPTH_WIDTH)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wr_acc),
        .waddr (wr_ptr[DEPTH_WIDTH-1:0]),
        .wdata (wr_data),
        .re    (fetch),
        .raddr (rd_ptr[DEPTH_WIDTH-1:0]),
        .rdata (ram_q)
    );

    if (FWFT == FIFO_FWFT) begin : g_fwft
        assign rd_data  = ram_q;
        assign rd_valid = !rd_empty;
    end else if (OUTPUT_REG != 0) begin : g_oreg
        logic                  valid_1, valid_2, valid_2_next;
        logic [DATA_WIDTH-1:0] data_2;

        assign valid_2_next = valid_1 && !flush;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_1 <= 1'b0;
                valid_2 <= 1'b0;
                data_2  <= '0;
            end else begin
                valid_1 <= rd_acc;
                valid_2 <= valid_2_next;
                if (valid_2_next) data_2 <= ram_q;
            end
        end

        assign rd_data  = data_2;
        assign rd_valid = valid_2;
    end else begin : g_std
        logic valid_1;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) valid_1 <= 1'b0;
            else        valid_1 <= rd_acc;
        end

        assign rd_data  = ram_q;
        assign rd_valid = valid_1;
    end

endmodule
